// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter width helper.
// Imported by seq_multiplier and mult_shift_add_step.
package seq_multiplier_pkg;

  localparam int MULT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for an iteration counter that must reach the value 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_step.sv
// One shift-add iteration: conditionally add A into the upper half, then shift right by one.
// Latency: purely combinational (0 cycles).
// Backpressure: none; it is evaluated every cycle and the caller decides when to register it.
module mult_shift_add_step
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic               b_lsb,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;

  // WIDTH+1-bit add keeps the carry, which becomes the new accumulator MSB after the shift.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (b_lsb ? {1'b0, a_in} : '0);
    acc_out = {sum, acc_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock; optional macro MULT_EARLY_TERM_EN.
// Latency: WIDTH edges after accept (early-term build: max(1, msb index of B + 1) edges).
// Backpressure: start is a level; a new operation is only accepted in IDLE, after start was seen low in DONE.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               ready
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] step_acc;

  mult_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_in  (acc_q),
    .a_in    (a_q),
    .b_lsb   (b_q[0]),
    .acc_out (step_acc)
  );

`ifdef MULT_EARLY_TERM_EN
  logic [CW-1:0] shamt;
`endif

  // Next-state logic: accept in IDLE, iterate in BUSY, wait for start to drop in DONE.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready_d   = ready_q;
`ifdef MULT_EARLY_TERM_EN
    shamt     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = step_acc;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
`ifdef MULT_EARLY_TERM_EN
        // Once no set bits remain in B, the outstanding shifts are applied in one go.
        shamt = CW'(WIDTH) - cnt_d;
        if ((b_d == '0) || (cnt_q == LAST_CNT)) begin
          product_d = step_acc >> shamt;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
`else
        if (cnt_q == LAST_CNT) begin
          product_d = step_acc;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier with WIDTH=8: directed corners plus random operands.
// Expected products come from plain multiplication; expected latency from B's highest set bit.
// Honours MULT_EARLY_TERM_EN the same way the design build does.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic [2*W-1:0] product;
  logic           ready;

  int n_checks;
  int n_errors;
  logic [2*W-1:0] prod_model;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges from accept until ready is expected high.
  function automatic int exp_lat(input logic [W-1:0] b);
    int lat;
`ifdef MULT_EARLY_TERM_EN
    lat = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) lat = i + 1;
    end
`else
    lat = W;
`endif
    return lat;
  endfunction

  // Runs one full handshake; called with time just after a rising edge and start low.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    int k;
    logic [2*W-1:0] held;
    logic [2*W-1:0] expv;
    held = prod_model;
    expv = 16'(a) * 16'(b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    chk("accept_ready_low", {31'd0, ready}, 32'd0);
    chk("accept_product_held", {16'd0, product}, {16'd0, held});
    k = 0;
    while (!ready && k < 20) begin
      if (scramble) begin
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
      end
      @(posedge clk); #1;
      k++;
      if (!ready) chk("busy_product_held", {16'd0, product}, {16'd0, held});
    end
    chk("latency", k, exp_lat(b));
    chk("product", {16'd0, product}, {16'd0, expv});
    prod_model = expv;
    @(posedge clk); #1;
    chk("done_hold_ready", {31'd0, ready}, 32'd1);
    chk("done_hold_product", {16'd0, product}, {16'd0, prod_model});
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_product", {16'd0, product}, {16'd0, prod_model});
    @(posedge clk); #1;
    chk("idle_no_launch", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    prod_model   = '0;
    reset        = 1'b1;
    start        = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {31'd0, ready}, 32'd0);

    // Basic and handshake sequence
    do_op(8'd7, 8'd9, 1'b0);
    do_op(8'd3, 8'd5, 1'b0);

    // Corners
    do_op(8'd0, 8'd200, 1'b0);
    do_op(8'd255, 8'd255, 1'b0);
    do_op(8'd1, 8'd128, 1'b0);
    do_op(8'd128, 8'd2, 1'b0);
    do_op(8'd50, 8'd3, 1'b0);
    do_op(8'd77, 8'd0, 1'b0);

    // Operands wiggle every cycle while busy
    do_op(8'd12, 8'd11, 1'b1);

    // Reset in the middle of an operation
    multiplicand = 8'd200;
    multiplier   = 8'd77;
    start        = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midop_reset_ready", {31'd0, ready}, 32'd0);
    chk("midop_reset_product", {16'd0, product}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    prod_model = '0;
    @(posedge clk); #1;
    chk("post_reset_ready", {31'd0, ready}, 32'd0);
    do_op(8'd6, 8'd6, 1'b0);

    // Random operands, some with scrambled inputs while busy
    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
